// File: rtl/code_conv_sched.sv
// Shares one combinational BCD/Gray/XS-3/XS-5 converter between two requesters.
// Round-robin grant, one-cycle converter drive, held result with id tag, saturating job counters.
//
// state | meaning
// IDLE  | ready asserted for the round-robin winner; job latched onto conv_b
// DRIVE | converter enabled with the latched job; conv_y/conv_done captured
// HOLD  | result presented on res_*; waits for res_ready
module code_conv_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [3:0]       a_data,
  input  logic [1:0]       a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [3:0]       b_data,
  input  logic [1:0]       b_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_y,
  output logic             res_id,
  output logic             res_err,
  output logic [7:0]       conv_b,
  output logic             conv_en_n,
  input  logic [7:0]       conv_y,
  input  logic             conv_done,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   last_b;
  logic   job_id;
  logic   in_idle;
  logic   pick_a;

  // A wins when alone, or on a tie when B had the previous grant.
  always_comb begin
    in_idle = (state == IDLE) && !rst;
    pick_a  = a_valid && (!b_valid || last_b);
    a_ready = in_idle && pick_a;
    b_ready = in_idle && b_valid && !pick_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      job_id    <= 1'b0;
      res_valid <= 1'b0;
      res_y     <= 8'h00;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
      conv_b    <= 8'h00;
      conv_en_n <= 1'b1;
      cnt_a     <= '0;
      cnt_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_ready || b_ready) begin
            conv_b    <= a_ready ? {a_data, 2'b00, a_op} : {b_data, 2'b00, b_op};
            conv_en_n <= 1'b0;
            job_id    <= b_ready;
            last_b    <= b_ready;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          res_y     <= conv_y;
          res_err   <= ~conv_done;
          res_id    <= job_id;
          res_valid <= 1'b1;
          conv_en_n <= 1'b1;
          conv_b    <= 8'h00;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_id) begin
              if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
            end else begin
              if (cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_conv_sched.sv
// Bench for code_conv_sched: directed scenarios plus a randomized run against a
// transaction-level model (job queues, round-robin pointer, expected-result queue).
module tb_code_conv_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, res_ready;
  logic [3:0] a_data, b_data;
  logic [1:0] a_op, b_op;
  logic [7:0] conv_y;
  logic       conv_done;
  logic       done_ok;

  logic       a_ready, b_ready, res_valid, res_id, res_err, conv_en_n;
  logic [7:0] res_y, conv_b;
  logic [7:0] cnt_a, cnt_b;

  logic       s_a_ready, s_b_ready, s_res_valid, s_res_id, s_res_err, s_conv_en_n;
  logic [7:0] s_res_y, s_conv_b;
  logic [1:0] s_cnt_a, s_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {logic [3:0] d; logic [1:0] op;} job_t;
  typedef struct packed {logic [7:0] y; logic id; logic err;} exp_t;

  always #5 clk = ~clk;

  function automatic logic [7:0] conv_fn(input logic [3:0] v, input logic [1:0] op);
    logic [7:0] w;
    w = {4'h0, v};
    case (op)
      2'd0:    return (v < 4'd10) ? w : w + 8'd6;
      2'd1:    return {4'h0, v[3], v[3] ^ v[2], v[2] ^ v[1], v[1] ^ v[0]};
      2'd2:    return (v < 4'd9) ? w + 8'd3 : w + 8'd57;
      default: return (v < 4'd10) ? w + 8'd5 : w + 8'd91;
    endcase
  endfunction

  // Converter model: garbage when disabled so a mis-timed capture shows up.
  assign conv_y    = conv_en_n ? 8'hA5 : conv_fn(conv_b[7:4], conv_b[1:0]);
  assign conv_done = !conv_en_n && done_ok;

  code_conv_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_op(b_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id),
    .res_err(res_err), .conv_b(conv_b), .conv_en_n(conv_en_n), .conv_y(conv_y),
    .conv_done(conv_done), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  code_conv_sched #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_data(a_data), .a_op(a_op),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_data(b_data), .b_op(b_op),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_y(s_res_y), .res_id(s_res_id),
    .res_err(s_res_err), .conv_b(s_conv_b), .conv_en_n(s_conv_en_n), .conv_y(conv_y),
    .conv_done(conv_done), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0; done_ok = 1'b1;
    a_data = 4'h0; a_op = 2'd0; b_data = 4'h0; b_op = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1; done_ok = 1'b1;
    a_data = 4'h5; a_op = 2'd2; b_data = 4'h3; b_op = 2'd1;
    tick();
    tick();
    n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {a_ready, b_ready}); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_y !== 8'h00) begin n_bad++; $display("FAIL reset_res_y got %h want 00", res_y); end
    n_cmp++; if ({res_id, res_err} !== 2'b00) begin n_bad++; $display("FAIL reset_id_err got %b want 00", {res_id, res_err}); end
    n_cmp++; if (conv_b !== 8'h00) begin n_bad++; $display("FAIL reset_conv_b got %h want 00", conv_b); end
    n_cmp++; if (conv_en_n !== 1'b1) begin n_bad++; $display("FAIL reset_conv_en_n got %b want 1", conv_en_n); end
    n_cmp++; if ({cnt_a, cnt_b} !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt got %h/%h want 0/0", cnt_a, cnt_b); end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1; a_data = 4'd5; a_op = 2'd2; a_valid = 1'b1;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL single_accept got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if ({conv_b, conv_en_n} !== {8'h52, 1'b0}) begin n_bad++; $display("FAIL single_drive got %h/%b want 52/0", conv_b, conv_en_n); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %b want 0", res_valid); end
    tick();
    n_cmp++; if ({res_valid, res_y, res_id, res_err} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL single_result got v=%b y=%h id=%b err=%b want 1/08/0/0", res_valid, res_y, res_id, res_err); end
    n_cmp++; if (conv_en_n !== 1'b1) begin n_bad++; $display("FAIL single_conv_off got %b want 1", conv_en_n); end
    tick();
    n_cmp++; if ({res_valid, cnt_a} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL single_done got v=%b cnt_a=%0d want 0/1", res_valid, cnt_a); end
  endtask

  task automatic test_alternate();
    logic [3:0] ad [3] = '{4'd12, 4'd6, 4'd3};
    logic [1:0] aop [3] = '{2'd0, 2'd1, 2'd3};
    logic [3:0] bd [3] = '{4'd13, 4'd9, 4'd0};
    logic [1:0] bop [3] = '{2'd3, 2'd2, 2'd0};
    logic [7:0] ey [6] = '{8'h12, 8'h68, 8'h05, 8'h42, 8'h08, 8'h00};
    int ia = 0;
    int ib = 0;
    do_reset();
    res_ready = 1'b1;
    a_valid = 1'b1; a_data = ad[0]; a_op = aop[0];
    b_valid = 1'b1; b_data = bd[0]; b_op = bop[0];
    for (int j = 0; j < 6; j++) begin
      #1;
      n_cmp++; if ({a_ready, b_ready} !== (j[0] ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL rr_grant job %0d got %b want %b", j, {a_ready, b_ready}, j[0] ? 2'b01 : 2'b10); end
      tick();
      if (!j[0]) begin
        ia++; if (ia < 3) begin a_data = ad[ia]; a_op = aop[ia]; end else a_valid = 1'b0;
      end else begin
        ib++; if (ib < 3) begin b_data = bd[ib]; b_op = bop[ib]; end else b_valid = 1'b0;
      end
      #1;
      n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL rr_busy_ready job %0d got %b want 00", j, {a_ready, b_ready}); end
      tick();
      n_cmp++; if ({res_valid, res_y, res_id} !== {1'b1, ey[j], j[0]}) begin
        n_bad++; $display("FAIL rr_result job %0d got v=%b y=%h id=%b want 1/%h/%b", j, res_valid, res_y, res_id, ey[j], j[0]); end
      tick();
    end
    n_cmp++; if ({cnt_a, cnt_b} !== {8'd3, 8'd3}) begin n_bad++; $display("FAIL rr_counts got %0d/%0d want 3/3", cnt_a, cnt_b); end
  endtask

  task automatic test_stall();
    do_reset();
    res_ready = 1'b0;
    a_valid = 1'b1; a_data = 4'd9; a_op = 2'd3;
    b_valid = 1'b1; b_data = 4'd2; b_op = 2'd1;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL stall_grant got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if ({res_valid, res_y, res_id, b_ready, cnt_a} !== {1'b1, 8'h0E, 1'b0, 1'b0, 8'd0}) begin
        n_bad++; $display("FAIL stall_hold cyc %0d got v=%b y=%h id=%b b_ready=%b cnt_a=%0d want 1/0e/0/0/0",
                          k, res_valid, res_y, res_id, b_ready, cnt_a); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    n_cmp++; if ({res_valid, b_ready, cnt_a} !== {1'b0, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL stall_release got v=%b b_ready=%b cnt_a=%0d want 0/1/1", res_valid, b_ready, cnt_a); end
    tick();
    b_valid = 1'b0;
    tick();
    n_cmp++; if ({res_y, res_id} !== {8'h03, 1'b1}) begin n_bad++; $display("FAIL stall_b_result got %h/%b want 03/1", res_y, res_id); end
    tick();
    n_cmp++; if (cnt_b !== 8'd1) begin n_bad++; $display("FAIL stall_cnt_b got %0d want 1", cnt_b); end
  endtask

  task automatic test_err();
    do_reset();
    res_ready = 1'b1;
    b_valid = 1'b1; b_data = 4'hB; b_op = 2'd0;
    tick();
    b_valid = 1'b0; done_ok = 1'b0;
    tick();
    n_cmp++; if ({res_valid, res_err, res_y, res_id} !== {1'b1, 1'b1, 8'h11, 1'b1}) begin
      n_bad++; $display("FAIL err_result got v=%b err=%b y=%h id=%b want 1/1/11/1", res_valid, res_err, res_y, res_id); end
    done_ok = 1'b1;
    tick();
    n_cmp++; if ({res_valid, cnt_b} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL err_count got v=%b cnt_b=%0d want 0/1", res_valid, cnt_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b1; a_valid = 1'b1; a_data = 4'd1; a_op = 2'd0;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    res_ready = 1'b0; a_valid = 1'b1; a_data = 4'd7; a_op = 2'd2;
    tick();
    a_valid = 1'b0;
    tick();
    n_cmp++; if ({res_valid, cnt_a} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL rmid_pre got v=%b cnt_a=%0d want 1/1", res_valid, cnt_a); end
    rst = 1'b1; res_ready = 1'b1;
    tick();
    n_cmp++; if ({res_valid, conv_en_n, cnt_a} !== {1'b0, 1'b1, 8'd0}) begin
      n_bad++; $display("FAIL rmid_hold_abort got v=%b en_n=%b cnt_a=%0d want 0/1/0", res_valid, conv_en_n, cnt_a); end
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1; b_data = 4'd3; b_op = 2'd0;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL rmid_tie1 got %b want 10", {a_ready, b_ready}); end
    tick();
    n_cmp++; if (conv_en_n !== 1'b0) begin n_bad++; $display("FAIL rmid_drive got %b want 0", conv_en_n); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({res_valid, conv_en_n, conv_b} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL rmid_drive_abort got v=%b en_n=%b b=%h want 0/1/00", res_valid, conv_en_n, conv_b); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL rmid_tie2 got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    n_cmp++; if ({res_valid, res_y, res_id} !== {1'b1, 8'h0A, 1'b0}) begin
      n_bad++; $display("FAIL rmid_result got v=%b y=%h id=%b want 1/0a/0", res_valid, res_y, res_id); end
    tick();
    n_cmp++; if ({cnt_a, cnt_b} !== {8'd1, 8'd0}) begin n_bad++; $display("FAIL rmid_cnt got %0d/%0d want 1/0", cnt_a, cnt_b); end
  endtask

  task automatic test_saturate();
    logic [1:0] want_s;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_data = 4'($urandom); a_op = 2'($urandom);
      #1;
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL sat_accept job %0d got %b want 1", i, a_ready); end
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      want_s = (i < 3) ? 2'(i + 1) : 2'd3;
      n_cmp++; if ({s_cnt_a, cnt_a} !== {want_s, 8'(i + 1)}) begin
        n_bad++; $display("FAIL sat_count job %0d got %0d/%0d want %0d/%0d", i, s_cnt_a, cnt_a, want_s, i + 1); end
    end
  endtask

  task automatic test_random();
    job_t qa[$];
    job_t qb[$];
    exp_t expq[$];
    exp_t e;
    job_t drv;
    logic last = 1'b1;
    logic busy = 1'b0;
    logic acc = 1'b0;
    logic cons = 1'b0;
    logic win = 1'b0;
    logic drive_now, exp_a, exp_b, exp_rv;
    int ca = 0, cb = 0, sa = 0, sb = 0;
    do_reset();
    drv = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      drive_now = acc;
      if (acc) begin
        drv = win ? qb.pop_front() : qa.pop_front();
        done_ok = ($urandom_range(0, 4) != 0);
        e.y = conv_fn(drv.d, drv.op); e.id = win; e.err = !done_ok;
        expq.push_back(e);
        busy = 1'b1; last = win;
      end
      if (cons) begin
        e = expq.pop_front();
        if (e.id) begin cb = (cb < 255) ? cb + 1 : 255; sb = (sb < 3) ? sb + 1 : 3; end
        else begin ca = (ca < 255) ? ca + 1 : 255; sa = (sa < 3) ? sa + 1 : 3; end
        busy = 1'b0;
      end
      if (qa.size() < 2 && $urandom_range(0, 2) == 0) qa.push_back(job_t'($urandom));
      if (qb.size() < 2 && $urandom_range(0, 2) == 0) qb.push_back(job_t'($urandom));
      a_valid = (qa.size() > 0);
      b_valid = (qb.size() > 0);
      {a_data, a_op} = a_valid ? qa[0] : job_t'($urandom);
      {b_data, b_op} = b_valid ? qb[0] : job_t'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_a = !busy && a_valid && (!b_valid || last);
      exp_b = !busy && b_valid && !exp_a;
      exp_rv = busy && !drive_now;
      n_cmp++; if ({a_ready, b_ready, s_a_ready, s_b_ready} !== {exp_a, exp_b, exp_a, exp_b}) begin
        n_bad++; $display("FAIL rnd_grant cyc %0d got %b%b/%b%b want %b%b", cyc, a_ready, b_ready, s_a_ready, s_b_ready, exp_a, exp_b); end
      if (drive_now) begin
        n_cmp++; if ({conv_en_n, conv_b, s_conv_en_n, s_conv_b} !== {1'b0, drv.d, 2'b00, drv.op, 1'b0, drv.d, 2'b00, drv.op}) begin
          n_bad++; $display("FAIL rnd_drive cyc %0d got %b/%h want 0/%h", cyc, conv_en_n, conv_b, {drv.d, 2'b00, drv.op}); end
      end else begin
        n_cmp++; if ({conv_en_n, conv_b, s_conv_en_n, s_conv_b} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
          n_bad++; $display("FAIL rnd_idle_conv cyc %0d got %b/%h want 1/00", cyc, conv_en_n, conv_b); end
      end
      n_cmp++; if ({res_valid, s_res_valid} !== {exp_rv, exp_rv}) begin
        n_bad++; $display("FAIL rnd_res_valid cyc %0d got %b/%b want %b", cyc, res_valid, s_res_valid, exp_rv); end
      if (exp_rv && expq.size() > 0) begin
        n_cmp++; if ({res_y, res_id, res_err, s_res_y, s_res_id, s_res_err} !== {expq[0], expq[0]}) begin
          n_bad++; $display("FAIL rnd_result cyc %0d got y=%h id=%b err=%b want y=%h id=%b err=%b",
                            cyc, res_y, res_id, res_err, expq[0].y, expq[0].id, expq[0].err); end
      end
      n_cmp++; if ({cnt_a, cnt_b, s_cnt_a, s_cnt_b} !== {8'(ca), 8'(cb), 2'(sa), 2'(sb)}) begin
        n_bad++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          cyc, cnt_a, cnt_b, s_cnt_a, s_cnt_b, ca, cb, sa, sb); end
      acc = exp_a || exp_b;
      win = exp_b;
      cons = exp_rv && res_ready;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0; done_ok = 1'b1;
    a_data = 4'h0; a_op = 2'd0; b_data = 4'h0; b_op = 2'd0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_err();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/code_conv_sched.md
# code_conv_sched

Two-requester scheduler that shares one combinational code converter (BCD / Gray / XS-3 / XS-5) between two clients. It arbitrates the requests round-robin and drives the converter's `B` bus and `enable_low`. It registers the converter output one cycle later and returns the result to the winning requester over a valid/ready channel, tagged with that requester's id. It also keeps per-requester completion counters for status readout.

## Interface
Parameters:
- `CNT_W`, default 8. Width of the completion counters.

Ports:
- `clk`, input, 1. Single clock; all state changes on the rising edge.
- `rst`, input, 1. Synchronous, active-high reset.
- `a_valid`, input, 1. Requester A has a job.
- `a_ready`, output, 1. Job A is accepted this cycle.
- `a_data`, input, 4. Requester A 4-bit value.
- `a_op`, input, 2. Requester A conversion opcode.
- `b_valid`, `b_ready`, `b_data`, `b_op`. Same as the A ports, for requester B.
- `res_valid`, output, 1. Result available.
- `res_ready`, input, 1. Consumer takes the result.
- `res_y`, output, 8. Conversion result.
- `res_id`, output, 1. Owner of the result: 0 = A, 1 = B.
- `res_err`, output, 1. The converter did not assert `fdone` when sampled.
- `conv_b`, output, 8. Converter `B` bus: `{data, 2'b00, op}`.
- `conv_en_n`, output, 1. Converter `enable_low`.
- `conv_y`, input, 8. Converter `Y`.
- `conv_done`, input, 1. Converter `fdone`.
- `cnt_a`, output, CNT_W. Completed jobs for A, saturating.
- `cnt_b`, output, CNT_W. Completed jobs for B, saturating.

## Operation
- Opcode map, as implemented by the converter: 00 = BCD, 01 = Gray, 10 = XS-3, 11 = XS-5.
  - BCD: v<10 ? v : v+6.
  - Gray: {v3, v3^v2, v2^v1, v1^v0}, zero-extended.
  - XS-3: v<9 ? v+3 : v+57.
  - XS-5: v<10 ? v+5 : v+91.
- The scheduler does not recompute results; it only forwards `conv_y`.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if any valid is high, grant one requester. The granted `x_ready` is high combinationally this cycle and the other ready is low. The job (data, op, id) is latched, and the next state is DRIVE. With no request, stay in IDLE.
  - DRIVE: `conv_en_n`=0 and `conv_b` shows the latched job. At the clock edge, capture `res_y`←`conv_y`, `res_err`←~`conv_done` and `res_id`. Go to HOLD.
  - HOLD: `res_valid`=1 and all outputs are stable. When `res_ready`=1: increment the owner's counter (saturate at all-ones, no wrap) and go to IDLE.
- Arbitration is round-robin on the last grant. If both valids are high in IDLE, grant the requester that was not granted last. After reset, the last-grant pointer is B, so A wins the first tie. A lone valid is always granted.
- `x_ready` is high only in IDLE. Requests arriving in DRIVE or HOLD wait; a requester must hold valid and payload until ready.
- Outside DRIVE: `conv_en_n`=1 and `conv_b`=0.
- `res_err`=1 still completes normally: the result is delivered and the counter increments.

## Timing
- Reset values:
  - state IDLE
  - `a_ready`=`b_ready`=0 during reset
  - `res_valid`=0, `res_y`=0, `res_id`=0, `res_err`=0
  - `conv_b`=0, `conv_en_n`=1
  - `cnt_a`=`cnt_b`=0
  - last-grant pointer = B
- Latency: acceptance in cycle N, converter driven in N+1, `res_valid` high in N+2. Minimum job-to-job spacing is 3 cycles when `res_ready` is held at 1.
- The result is dropped only by reset. `res_valid` stays high, with `res_y`, `res_id` and `res_err` frozen, until `res_ready`.
- Reset asserted in DRIVE or HOLD aborts the job: no result is delivered, no counter changes, and the FSM is in IDLE on the cycle after reset is released.
- A counter at max plus a completion stays at max.
- `res_ready` high while `res_valid` is low has no effect.

## Test plan
- A: data=5, op=10. Response: `a_ready` in cycle 0; `conv_b`=0x52 and `conv_en_n`=0 in cycle 1; `res_valid` in cycle 2 with `res_y`=0x08, `res_id`=0, `res_err`=0; `cnt_a`=1.
- A and B both valid from reset, each with 3 jobs: grants go A, B, A, B, A, B. Covers A 12/op00 → 0x12, B 13/op11 → 0x68, A 6/op01 → 0x05, B 9/op10 → 0x42.
- `res_ready` held low for 10 cycles in HOLD: `res_valid` and `res_y` stay constant, `b_ready` stays 0 while B is valid, and there is no counter change. Releasing `res_ready` completes the job and B is then granted.
- `conv_done` forced to 0 during DRIVE: result delivered with `res_err`=1 and the counter incremented.
- Reset pulsed during HOLD: `res_valid` drops, no counter increment, `conv_en_n`=1; the next request is served normally, with A winning a tie.
- CNT_W=2, A completes 5 jobs: `cnt_a` reads 1, 2, 3, 3, 3.
